reg_file_sweep: RTL and testbench

REG_FILE_SWEEP -- requirements
Module: reg_file_sweep

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_rport.sv | 48 ++++
 rtl/reg_file_sweep.sv | 91 +++++++++
 tb/tb_reg_file_sweep.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the swept-clear register file.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;

  // CLEAR: array being zeroed, writes dropped. RUN: normal operation.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_rport.sv
// One registered read port of the register file.
// Optional macro REG_FILE_BYPASS_EN: a read of the index being written on the
// same edge returns the incoming write data (write-first) instead of the
// stored value (read-first).
module reg_file_rport #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] rd_id,
  input  logic [ADDR_W-1:0] wr_id,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_next;

  // Select stored word, or the in-flight write on an index collision.
  always_comb begin
    rd_next = arr_data;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (wr_id == rd_id)) begin
      rd_next = wr_data;
    end
`endif
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_id, wr_data, rd_id};
`endif

  // Output register; forced to zero outside RUN so partially cleared data never leaks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (run) begin
      rd_data <= rd_next;
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/reg_file_sweep.sv
// Register file with two registered read ports and one write port. After reset
// the array is zeroed one entry per cycle by a sweep counter; Reg_Ready rises
// once the last entry is cleared. There is no parallel reset of the array.
// Optional macro REG_FILE_BYPASS_EN selects write-first read behaviour.
module reg_file_sweep
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] RS_ID,
  input  logic [ADDR_W-1:0] RT_ID,
  input  logic [ADDR_W-1:0] REG_W_ID,
  input  logic              Reg_WE,
  input  logic [DATA_W-1:0] Reg_WData,
  output logic [DATA_W-1:0] Reg_RData1,
  output logic [DATA_W-1:0] Reg_RData2,
  output logic              Reg_Ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              run;
  logic [DATA_W-1:0] rs_word;
  logic [DATA_W-1:0] rt_word;

  assign run       = (state == RUN);
  assign Reg_Ready = run;
  assign rs_word   = regs[RS_ID];
  assign rt_word   = regs[RT_ID];

  // Sweep sequencing: leave CLEAR on the edge that clears the last entry.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
    end else if (state == CLEAR) begin
      sweep_cnt <= sweep_cnt + ADDR_W'(1);
      if (&sweep_cnt) begin
        state <= RUN;
      end
    end
  end

  // Array write: sweep zeroes in CLEAR (user writes dropped), user writes in RUN.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (!run) begin
        regs[sweep_cnt] <= '0;
      end else if (Reg_WE) begin
        regs[REG_W_ID] <= Reg_WData;
      end
    end
  end

  reg_file_rport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rport1 (
    .clk      (CLK),
    .rst_n    (RST_N),
    .run      (run),
    .rd_id    (RS_ID),
    .wr_id    (REG_W_ID),
    .wr_en    (Reg_WE),
    .wr_data  (Reg_WData),
    .arr_data (rs_word),
    .rd_data  (Reg_RData1)
  );

  reg_file_rport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rport2 (
    .clk      (CLK),
    .rst_n    (RST_N),
    .run      (run),
    .rd_id    (RT_ID),
    .wr_id    (REG_W_ID),
    .wr_en    (Reg_WE),
    .wr_data  (Reg_WData),
    .arr_data (rt_word),
    .rd_data  (Reg_RData2)
  );

endmodule

// File: tb/tb_reg_file_sweep.sv
// Self-checking bench for reg_file_sweep: a default 16x8 instance and a 32x32
// instance, checked every cycle against an array-based reference model.
// Honours REG_FILE_BYPASS_EN for the collision expectation.
module tb_reg_file_sweep;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Default-size instance
  logic        s_rst_n, s_we, s_rdy;
  logic [2:0]  s_rs, s_rt, s_wid;
  logic [15:0] s_wd, s_rd1, s_rd2;
  // Wide instance
  logic        b_rst_n, b_we, b_rdy;
  logic [4:0]  b_rs, b_rt, b_wid;
  logic [31:0] b_wd, b_rd1, b_rd2;

  reg_file_sweep u_small (
    .CLK        (CLK),
    .RST_N      (s_rst_n),
    .RS_ID      (s_rs),
    .RT_ID      (s_rt),
    .REG_W_ID   (s_wid),
    .Reg_WE     (s_we),
    .Reg_WData  (s_wd),
    .Reg_RData1 (s_rd1),
    .Reg_RData2 (s_rd2),
    .Reg_Ready  (s_rdy)
  );

  reg_file_sweep #(
    .DATA_W (32),
    .ADDR_W (5)
  ) u_big (
    .CLK        (CLK),
    .RST_N      (b_rst_n),
    .RS_ID      (b_rs),
    .RT_ID      (b_rt),
    .REG_W_ID   (b_wid),
    .Reg_WE     (b_we),
    .Reg_WData  (b_wd),
    .Reg_RData1 (b_rd1),
    .Reg_RData2 (b_rd2),
    .Reg_Ready  (b_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          big;
  int unsigned depth;
  logic [31:0] mask;
  logic [31:0] m_mem [32];
  int          clr_left;
  logic [31:0] e1, e2;
  logic        e_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive the selected instance, advance the model, compare after the edge.
  task automatic step(input logic rst, input logic we, input int unsigned w,
                      input logic [31:0] wd, input int unsigned rs, input int unsigned rt);
    int unsigned wi, ri, ti;
    logic [31:0] c1, c2;
    logic        c_rdy;
    wi = w % depth;
    ri = rs % depth;
    ti = rt % depth;
    if (big) begin
      b_rst_n = rst; b_we = we; b_wid = 5'(wi); b_wd = wd; b_rs = 5'(ri); b_rt = 5'(ti);
      s_rst_n = 1'b0;
    end else begin
      s_rst_n = rst; s_we = we; s_wid = 3'(wi); s_wd = wd[15:0]; s_rs = 3'(ri); s_rt = 3'(ti);
      b_rst_n = 1'b0;
    end
    // Model: reset restarts a DEPTH-cycle clear; reads are zero until it completes.
    if (!rst) begin
      clr_left = int'(depth);
      e1 = '0;
      e2 = '0;
    end else if (clr_left > 0) begin
      m_mem[int'(depth) - clr_left] = '0;
      clr_left--;
      e1 = '0;
      e2 = '0;
    end else begin
      e1 = m_mem[ri];
      e2 = m_mem[ti];
`ifdef REG_FILE_BYPASS_EN
      if (we && (ri == wi)) e1 = wd & mask;
      if (we && (ti == wi)) e2 = wd & mask;
`endif
      if (we) m_mem[wi] = wd & mask;
    end
    e_rdy = rst && (clr_left == 0);
    @(posedge CLK);
    #1;
    if (big) begin
      c_rdy = b_rdy; c1 = b_rd1; c2 = b_rd2;
    end else begin
      c_rdy = s_rdy; c1 = {16'h0, s_rd1}; c2 = {16'h0, s_rd2};
    end
    check("ready", 32'(c_rdy), 32'(e_rdy));
    check("rdata1", c1, e1);
    check("rdata2", c2, e2);
  endtask

  initial begin : stim
    int cyc;
    logic [31:0] coll_exp;
    s_rst_n = 1'b0; s_we = 1'b0; s_rs = '0; s_rt = '0; s_wid = '0; s_wd = '0;
    b_rst_n = 1'b0; b_we = 1'b0; b_rs = '0; b_rt = '0; b_wid = '0; b_wd = '0;

    // ---- Default 16-bit x 8 instance ----
    big = 1'b0; depth = 8; mask = 32'h0000_FFFF; clr_left = 8;
    step(1'b0, 1'b0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0, 0);

    // Release; hammer writes to entry 5 throughout CLEAR and time the sweep.
    cyc = 0;
    for (int i = 0; i < 40 && !s_rdy; i++) begin
      step(1'b1, 1'b1, 5, 32'hBEEF, i, i + 3);
      cyc++;
    end
    check("ready_latency", 32'(cyc), 32'd8);

    // Every entry reads zero, including the one targeted during CLEAR.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 0, i, 7 - i);
    step(1'b1, 1'b0, 0, 0, 5, 5);
    check("entry5_after_clear", {16'h0, s_rd1}, 32'h0);

    // Write 123 to index 3, then read 3 and 7.
    step(1'b1, 1'b1, 3, 32'd123, 0, 0);
    step(1'b1, 1'b0, 0, 0, 3, 7);
    check("rd1_idx3", {16'h0, s_rd1}, 32'd123);
    check("rd2_idx7", {16'h0, s_rd2}, 32'd0);

    // Same-edge write/read collision on index 2.
`ifdef REG_FILE_BYPASS_EN
    coll_exp = 32'h0000_00AA;
`else
    coll_exp = 32'h0000_0000;
`endif
    step(1'b1, 1'b1, 2, 32'h00AA, 2, 0);
    check("collision", {16'h0, s_rd1}, coll_exp);
    step(1'b1, 1'b0, 0, 0, 2, 2);
    check("after_collision", {16'h0, s_rd1}, 32'h0000_00AA);

    // Random traffic in RUN.
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
    end

    // Reset from RUN, then reset again at sweep count 4.
    step(1'b0, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i, $urandom, i, i);
    step(1'b0, 1'b1, 1, 32'h1234, 0, 0);
    cyc = 0;
    for (int i = 0; i < 40 && !s_rdy; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
      cyc++;
    end
    check("restart_latency", 32'(cyc), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 0, i, i + 1);

    // ---- 32-bit x 32 instance ----
    big = 1'b1; depth = 32; mask = 32'hFFFF_FFFF; clr_left = 32;
    step(1'b0, 1'b0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0, 0);
    cyc = 0;
    for (int i = 0; i < 80 && !b_rdy; i++) begin
      step(1'b1, 1'b1, 31, 32'hDEAD_BEEF, i, 31 - i);
      cyc++;
    end
    check("wide_ready_latency", 32'(cyc), 32'd32);
    step(1'b1, 1'b1, 31, 32'hFFFF_0001, 0, 0);
    step(1'b1, 1'b0, 0, 0, 31, 30);
    check("wide_rd1_idx31", b_rd1, 32'hFFFF_0001);
    check("wide_rd2_idx30", b_rd2, 32'h0);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
